// File: rtl/uart_tx_fifo_drain_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_drain_if
// Read-side handshake between a register-file FIFO and the UART transmitter
// that drains it.
//   iempty   FIFO empty flag (FIFO -> transmitter)
//   ir_data  FIFO combinational read data, valid while iempty=0
//   ord      one-cycle pop strobe (transmitter -> FIFO)
// Modports: master = FIFO side, slave = transmitter side.
// ----------------------------------------------------------------------------
interface uart_tx_fifo_drain_if #(
    parameter int pDBIT = 8
);
    logic             iempty;
    logic [pDBIT-1:0] ir_data;
    logic             ord;

    modport master (output iempty, output ir_data, input ord);
    modport slave  (input iempty, input ir_data, output ord);
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_drain
// Serial transmitter that pops one word per frame from the upstream FIFO and
// sends it LSB-first: 1 start bit, pDBIT data bits, pSB_TICK/16 stop bits.
// Contains its own oversampling baud divider (16 ticks per bit).
//   iclk      system clock, rising edge
//   ireset_n  asynchronous active-low reset
//   fifo      FIFO read handshake (slave modport: iempty, ir_data in; ord out)
//   otx       registered serial line, idles high
//   obusy     high while a frame is in progress (state != IDLE)
//   odone     one-cycle pulse in the last STOP cycle, before IDLE is entered
// ----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
    parameter int pDBIT     = 8,
    parameter int pSB_TICK  = 16,
    parameter int pBAUD_DIV = 163
) (
    input  logic                 iclk,
    input  logic                 ireset_n,
    uart_tx_fifo_drain_if.slave  fifo,
    output logic                 otx,
    output logic                 obusy,
    output logic                 odone
);

    localparam int BAUD_W = $clog2(pBAUD_DIV);
    localparam int BIT_W  = (pDBIT > 1) ? $clog2(pDBIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(pBAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(pDBIT - 1);
    localparam logic [5:0]        BIT_TICK_LAST  = 6'd15;
    localparam logic [5:0]        STOP_TICK_LAST = 6'(pSB_TICK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [5:0]         tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [pDBIT-1:0]   shreg_q, shreg_d;
    logic               otx_q, otx_d;

    logic tick;
    logic bit_end;

    // One oversampling tick per pBAUD_DIV cycles, only while a frame runs.
    assign tick    = (state_q != S_IDLE) && (baud_q == BAUD_LAST);
    assign bit_end = tick && (tick_cnt_q == BIT_TICK_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!fifo.iempty) state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA:  if (bit_end && (bit_cnt_q == BIT_LAST)) state_d = S_STOP;
            S_STOP:  if (tick && (tick_cnt_q == STOP_TICK_LAST)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: baud divider, tick/bit counters, shift register
    // ------------------------------------------------------------------
    always_comb begin
        baud_d     = baud_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;

        // Divider is pinned at 0 in IDLE so the first tick lands a fixed
        // number of cycles after the pop.
        if (state_q == S_IDLE || baud_q == BAUD_LAST) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end

        if (state_d != state_q) begin
            tick_cnt_d = '0;
        end else if (bit_end && state_q == S_DATA) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        if (state_q == S_IDLE) begin
            bit_cnt_d = '0;
            if (!fifo.iempty) begin
                shreg_d = fifo.ir_data;
            end
        end else if (state_q == S_DATA && bit_end) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
            shreg_d   = shreg_q >> 1;
        end
    end

    // Line level is computed from the *next* state so the registered otx
    // changes on the same edge as the state it belongs to.
    always_comb begin
        unique case (state_d)
            S_START: otx_d = 1'b0;
            S_DATA:  otx_d = shreg_d[0];
            default: otx_d = 1'b1;
        endcase
    end

    // NOTE: the shift register is reset along with the control state: it is
    // a single word, not a memory array, and a defined value after reset
    // costs nothing.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            baud_q     <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            otx_q      <= 1'b1;
        end else begin
            baud_q     <= baud_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            otx_q      <= otx_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The pop strobe is gated by reset: the state register already reads
    // IDLE during reset and must not pop the FIFO while held there.
    always_comb begin
        fifo.ord = ireset_n && (state_q == S_IDLE) && !fifo.iempty;
        obusy    = (state_q != S_IDLE);
        odone    = (state_q == S_STOP) && tick && (tick_cnt_q == STOP_TICK_LAST);
    end

    assign otx = otx_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
// Directed bench for uart_tx_fifo_drain with pBAUD_DIV=4 (B=64 cycles/bit).
// Instance A (pSB_TICK=16) is fed by a small queue-based FIFO model.
// Instance B (pSB_TICK=32) sees a permanently non-empty FIFO of 0x00 words.
// Inputs change just after a rising edge; outputs are sampled on falling edges.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;

    localparam int DIV = 4;

    logic iclk;
    logic ireset_n;

    uart_tx_fifo_drain_if #(.pDBIT(8)) fifo_a_if ();
    uart_tx_fifo_drain_if #(.pDBIT(8)) fifo_b_if ();

    logic otx_a, obusy_a, odone_a;
    logic otx_b, obusy_b, odone_b;

    uart_tx_fifo_drain #(.pDBIT(8), .pSB_TICK(16), .pBAUD_DIV(DIV)) dut_a (
        .iclk     (iclk),
        .ireset_n (ireset_n),
        .fifo     (fifo_a_if),
        .otx      (otx_a),
        .obusy    (obusy_a),
        .odone    (odone_a)
    );

    uart_tx_fifo_drain #(.pDBIT(8), .pSB_TICK(32), .pBAUD_DIV(DIV)) dut_b (
        .iclk     (iclk),
        .ireset_n (ireset_n),
        .fifo     (fifo_b_if),
        .otx      (otx_b),
        .obusy    (obusy_b),
        .odone    (odone_b)
    );

    assign fifo_b_if.iempty  = 1'b0;
    assign fifo_b_if.ir_data = 8'h00;

    int checks = 0;
    int errors = 0;

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // ------------------------------------------------------------------
    // FIFO model for instance A
    // ------------------------------------------------------------------
    logic [7:0] fifo_q[$];
    bit         force_empty = 1'b0;
    bit         pop_req     = 1'b0;

    task automatic refresh_fifo();
        fifo_a_if.iempty  = (fifo_q.size() == 0) || force_empty;
        fifo_a_if.ir_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        refresh_fifo();
    endtask

    // Push from an idle line: change inputs just after a rising edge so the
    // pop sampler on the next falling edge sees a settled ord.
    task automatic push_word_sync(input logic [7:0] w);
        @(posedge iclk);
        #1;
        push_word(w);
    endtask

    always @(negedge iclk) pop_req = fifo_a_if.ord;

    always @(posedge iclk) begin
        #1;
        if (pop_req && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            refresh_fifo();
        end
        pop_req = 1'b0;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Advance falling edges until ord is seen (checking the current one
    // first). An expired budget counts as a failed comparison.
    task automatic wait_ord(input string name, input bit sel_b, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel_b ? fifo_b_if.ord : fifo_a_if.ord) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge iclk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: ord not seen within %0d cycles (got 0, want 1)", name, budget);
        end
    endtask

    // Called on the falling edge of the ord cycle N. Checks cycles N+1 ..
    // N+641 of instance A against the expected frame of word w.
    task automatic check_frame(input string name, input logic [7:0] w,
                               input bit expect_next, input int push_k,
                               input logic [7:0] push_w);
        logic [7:0] word;
        logic       exp_otx;
        word = w;
        for (int k = 1; k <= 640; k++) begin
            @(negedge iclk);
            if (push_k > 0 && k == push_k) push_word(push_w);
            if (push_k > 0 && push_k + 200 < 640) begin
                if (k == push_k + 100) begin force_empty = 1'b1; refresh_fifo(); end
                if (k == push_k + 200) begin force_empty = 1'b0; refresh_fifo(); end
            end
            if (k <= 64)       exp_otx = 1'b0;
            else if (k <= 576) exp_otx = word[(k - 65) / 64];
            else               exp_otx = 1'b1;

            checks++;
            if (otx_a !== exp_otx) begin
                errors++;
                $display("FAIL %s otx k=%0d: got %b want %b", name, k, otx_a, exp_otx);
            end
            checks++;
            if (obusy_a !== 1'b1) begin
                errors++;
                $display("FAIL %s obusy k=%0d: got %b want 1", name, k, obusy_a);
            end
            checks++;
            if (fifo_a_if.ord !== 1'b0) begin
                errors++;
                $display("FAIL %s ord k=%0d: got %b want 0", name, k, fifo_a_if.ord);
            end
            checks++;
            if (odone_a !== (k == 640)) begin
                errors++;
                $display("FAIL %s odone k=%0d: got %b want %b", name, k, odone_a, (k == 640));
            end
        end
        @(negedge iclk);
        checks++;
        if (obusy_a !== 1'b0 || odone_a !== 1'b0 || otx_a !== 1'b1) begin
            errors++;
            $display("FAIL %s idle k=641: got busy=%b done=%b tx=%b want 0 0 1",
                     name, obusy_a, odone_a, otx_a);
        end
        checks++;
        if (fifo_a_if.ord !== expect_next) begin
            errors++;
            $display("FAIL %s next ord k=641: got %b want %b", name, fifo_a_if.ord, expect_next);
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge iclk);
            checks++;
            if (fifo_a_if.ord !== 1'b0 || otx_a !== 1'b1 || obusy_a !== 1'b0) begin
                errors++;
                $display("FAIL %s k=%0d: got ord=%b tx=%b busy=%b want 0 1 0",
                         name, k, fifo_a_if.ord, otx_a, obusy_a);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        ireset_n = 1'b0;
        push_word(8'h55);
        for (int k = 0; k < 20; k++) begin
            @(negedge iclk);
            checks++;
            if (otx_a !== 1'b1 || fifo_a_if.ord !== 1'b0 || obusy_a !== 1'b0 || odone_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold k=%0d: got tx=%b ord=%b busy=%b done=%b want 1 0 0 0",
                         k, otx_a, fifo_a_if.ord, obusy_a, odone_a);
            end
        end
        @(posedge iclk);
        #1;
        ireset_n = 1'b1;
        @(negedge iclk);
        checks++;
        if (fifo_a_if.ord !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ord: got %b want 1", fifo_a_if.ord);
        end
    endtask

    task automatic test_single_frame();
        check_frame("single_55", 8'h55, 1'b0, 0, 8'h00);
        check_idle("single_after", 100);
    endtask

    task automatic test_back_to_back();
        push_word_sync(8'hA3);
        push_word(8'h0F);
        wait_ord("b2b_first_ord", 1'b0, 10);
        check_frame("b2b_A3", 8'hA3, 1'b1, 0, 8'h00);
        check_frame("b2b_0F", 8'h0F, 1'b0, 0, 8'h00);
        check_idle("b2b_after", 20);
    endtask

    task automatic test_reset_mid_frame();
        push_word_sync(8'h34);
        push_word(8'h96);
        wait_ord("midrst_ord", 1'b0, 10);
        // Land in the middle of data bit 3 (bit 3 of 0x34 is 0).
        repeat (65 + 3 * 64 + 20) @(negedge iclk);
        checks++;
        if (otx_a !== 1'b0) begin
            errors++;
            $display("FAIL midrst_bit3: got %b want 0", otx_a);
        end
        ireset_n = 1'b0;
        #1;
        checks++;
        if (otx_a !== 1'b1 || obusy_a !== 1'b0 || fifo_a_if.ord !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: got tx=%b busy=%b ord=%b want 1 0 0",
                     otx_a, obusy_a, fifo_a_if.ord);
        end
        repeat (3) @(posedge iclk);
        #1;
        ireset_n = 1'b1;
        @(negedge iclk);
        checks++;
        if (fifo_a_if.ord !== 1'b1) begin
            errors++;
            $display("FAIL midrst_release_ord: got %b want 1", fifo_a_if.ord);
        end
        check_frame("midrst_96", 8'h96, 1'b0, 0, 8'h00);
        check_idle("midrst_after", 20);
    endtask

    task automatic test_empty_gating();
        check_idle("empty_hold", 1000);
        push_word_sync(8'h5A);
        wait_ord("gate_ord", 1'b0, 10);
        // A word arrives mid-frame and iempty toggles: no early pop.
        check_frame("gate_5A", 8'h5A, 1'b1, 300, 8'h11);
        // A word arrives in the final STOP cycle: pop waits for IDLE.
        check_frame("gate_11", 8'h11, 1'b1, 640, 8'hC6);
        check_frame("gate_C6", 8'hC6, 1'b0, 0, 8'h00);
        check_idle("gate_after", 20);
    endtask

    task automatic test_stop_length();
        logic exp_otx;
        @(negedge iclk);
        wait_ord("stop32_ord", 1'b1, 1000);
        for (int k = 1; k <= 704; k++) begin
            @(negedge iclk);
            exp_otx = (k > 576);
            checks++;
            if (otx_b !== exp_otx || fifo_b_if.ord !== 1'b0 || obusy_b !== 1'b1) begin
                errors++;
                $display("FAIL stop32 k=%0d: got tx=%b ord=%b busy=%b want %b 0 1",
                         k, otx_b, fifo_b_if.ord, obusy_b, exp_otx);
            end
            checks++;
            if (odone_b !== (k == 704)) begin
                errors++;
                $display("FAIL stop32 odone k=%0d: got %b want %b", k, odone_b, (k == 704));
            end
        end
        @(negedge iclk);
        checks++;
        if (fifo_b_if.ord !== 1'b1 || obusy_b !== 1'b0) begin
            errors++;
            $display("FAIL stop32 spacing k=705: got ord=%b busy=%b want 1 0",
                     fifo_b_if.ord, obusy_b);
        end
    endtask

    initial begin
        ireset_n = 1'b0;
        refresh_fifo();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_empty_gating();
        test_stop_length();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
